// File: rtl/stepper_ramp_driver.sv
// stepper_ramp_driver
//   Drives a 4-phase stepper from a run/direction/rate request. The step rate ramps one
//   level per RAMP_STEPS steps toward the requested level. A direction reversal or a
//   disable always decelerates to rate 0 first.
//
//   Optional build macro: STEPPER_HALF_STEP_EN selects the 8-entry half-step table
//   (3-bit phase index). When undefined, the 4-entry full-step table is used.
//
// Ports
//   clk           system clock
//   rst           synchronous active-high reset
//   rot_en_i      run request (level)
//   rot_dir_i     0 = forward (index +1), 1 = reverse (index -1)
//   set_rate_i    requested rate level, 7 = fastest
//   f_o           coil phase drive
//   step_pulse_o  one-cycle strobe per phase advance
//   cur_rate_o    rate level currently in effect
//   busy_o        high whenever the driver is not idle
module stepper_ramp_driver #(
  parameter int unsigned BASE_DIV   = 25000,
  parameter int unsigned RAMP_STEPS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rot_en_i,
  input  logic       rot_dir_i,
  input  logic [2:0] set_rate_i,
  output logic [3:0] f_o,
  output logic       step_pulse_o,
  output logic [2:0] cur_rate_o,
  output logic       busy_o
);

  localparam int unsigned TimerW = $clog2(BASE_DIV * 128);
  localparam int unsigned PerW   = TimerW + 1;
  localparam int unsigned RampW  = (RAMP_STEPS > 1) ? $clog2(RAMP_STEPS) : 1;
  localparam logic [RampW-1:0] RampLast = RampW'(RAMP_STEPS - 1);

`ifdef STEPPER_HALF_STEP_EN
  localparam int unsigned IdxW = 3;
`else
  localparam int unsigned IdxW = 2;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StStopping, StReversing} state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic               dir_q, dir_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [RampW-1:0]   ramp_q, ramp_d;
  logic [2:0]         rate_q, rate_d;
  logic [3:0]         f_q, f_d;
  logic               pulse_q, pulse_d;
  logic [2:0]         target;
  logic               boundary;

  // Timer reload value for a rate level: (BASE_DIV << (7 - r)) - 1.
  function automatic logic [TimerW-1:0] reload(input logic [2:0] r);
    logic [PerW-1:0] p;
    p = PerW'(BASE_DIV) << (3'd7 - r);
    return TimerW'(p - PerW'(1));
  endfunction

  function automatic logic [3:0] coil(input logic [IdxW-1:0] i);
    logic [3:0] c;
`ifdef STEPPER_HALF_STEP_EN
    case (i)
      3'd0:    c = 4'b0001;
      3'd1:    c = 4'b0011;
      3'd2:    c = 4'b0010;
      3'd3:    c = 4'b0110;
      3'd4:    c = 4'b0100;
      3'd5:    c = 4'b1100;
      3'd6:    c = 4'b1000;
      default: c = 4'b1001;
    endcase
`else
    case (i)
      2'd0:    c = 4'b0011;
      2'd1:    c = 4'b0110;
      2'd2:    c = 4'b1100;
      default: c = 4'b1001;
    endcase
`endif
    return c;
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dir_d    = dir_q;
    timer_d  = timer_q;
    ramp_d   = ramp_q;
    rate_d   = rate_q;
    pulse_d  = 1'b0;
    target   = (state_q == StRun) ? set_rate_i : 3'd0;
    boundary = (state_q != StIdle) && (timer_q == '0);

    if (state_q != StIdle) begin
      if (boundary) begin
        idx_d   = dir_q ? idx_q - IdxW'(1) : idx_q + IdxW'(1);
        pulse_d = 1'b1;
        if (rate_q == target) begin
          ramp_d = '0;
        end else if (ramp_q == RampLast) begin
          ramp_d = '0;
          rate_d = (target > rate_q) ? rate_q + 3'd1 : rate_q - 3'd1;
        end else begin
          ramp_d = ramp_q + RampW'(1);
        end
        // Next period follows the rate that results from this boundary's ramp update.
        timer_d = reload(rate_d);
      end else begin
        timer_d = timer_q - TimerW'(1);
      end
    end

    case (state_q)
      StIdle: begin
        if (rot_en_i) begin
          dir_d   = rot_dir_i;
          rate_d  = 3'd0;
          ramp_d  = '0;
          timer_d = reload(3'd0);
          state_d = StRun;
        end
      end
      StRun: begin
        if (!rot_en_i) begin
          state_d = StStopping;
        end else if (rot_dir_i != dir_q) begin
          state_d = StReversing;
        end
      end
      StStopping: begin
        if (rot_en_i) begin
          state_d = (rot_dir_i == dir_q) ? StRun : StReversing;
        end else if (boundary && (rate_d == 3'd0)) begin
          state_d = StIdle;
        end
      end
      StReversing: begin
        if (!rot_en_i) begin
          state_d = StStopping;
        end else if (boundary && (rate_d == 3'd0)) begin
          // This boundary's step already went the old way; new direction from here on.
          dir_d   = rot_dir_i;
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase

    // Coils are released in idle; otherwise they follow the phase index.
    f_d = (state_d == StIdle) ? 4'b0000 : coil(idx_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      dir_q   <= 1'b0;
      timer_q <= '0;
      ramp_q  <= '0;
      rate_q  <= 3'd0;
      f_q     <= 4'b0000;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
      ramp_q  <= ramp_d;
      rate_q  <= rate_d;
      f_q     <= f_d;
      pulse_q <= pulse_d;
    end
  end

  assign f_o          = f_q;
  assign step_pulse_o = pulse_q;
  assign cur_rate_o   = rate_q;
  assign busy_o       = (state_q != StIdle);

endmodule
